// File: rtl/toggle_handshake_receiver.sv
// rtl/toggle_handshake_receiver.sv - two-phase toggle handshake receiver with event counter and overrun flag
module toggle_handshake_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_t,
    input  logic             evt_ready,
    input  logic             clr_overrun,
    output logic             evt_valid,
    output logic             ack_t,
    output logic [CNT_W-1:0] evt_count,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   lvl_cap_q, lvl_cap_d;
    logic                   evt_valid_q, evt_valid_d;
    logic                   ack_q, ack_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovr_q, ovr_d;

    // Only the last stage of the chain is safe to use; earlier stages may be metastable.
    assign req_sync = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous request level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_t};
        end
    end

    // Next-state logic: IDLE detects a new level, PEND holds it until the consumer accepts.
    always_comb begin
        state_d     = state_q;
        lvl_cap_d   = lvl_cap_q;
        evt_valid_d = evt_valid_q;
        ack_d       = ack_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;
        // Clear first so that a set in the same cycle takes priority.
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                evt_valid_d = 1'b0;
                if (req_sync != ack_q) begin
                    lvl_cap_d   = req_sync;
                    state_d     = PEND;
                    evt_valid_d = 1'b1;
                end
            end
            PEND: begin
                evt_valid_d = 1'b1;
                // Sender moved again before we acknowledged the captured level.
                if (req_sync != lvl_cap_q) begin
                    ovr_d = 1'b1;
                end
                if (evt_ready) begin
                    ack_d       = lvl_cap_q;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                    evt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lvl_cap_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_cap_q   <= lvl_cap_d;
            evt_valid_q <= evt_valid_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign ack_t     = ack_q;
    assign evt_count = cnt_q;
    assign overrun   = ovr_q;

endmodule
